// File: rtl/snake_pkg.sv
// Shared colours and FSM state encoding for the snake frame builder.
// Optional score pixel is enabled with SCORE_OVERLAY_EN.
package snake_pkg;

  localparam logic [23:0] BG_COLOR    = 24'h000000;
  localparam logic [23:0] FOOD_COLOR  = 24'h001100;
  localparam logic [23:0] BODY_COLOR  = 24'h110000;
  localparam logic [23:0] HEAD_COLOR  = 24'h111100;
  localparam logic [23:0] SCORE_COLOR = 24'h000011;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCORE,
    FOOD,
    BODY,
    SWAP
  } state_e;

endpackage

// File: rtl/snake_frame_builder_if.sv
// Game/serialiser-side bundle of the snake frame builder.
// score_position exists only when SCORE_OVERLAY_EN is defined.
interface snake_frame_builder_if #(
  parameter int MAX_LEN = 8,
  parameter int IDX_W   = 6,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic                     frame_req;
  logic [LEN_W-1:0]         snake_len;
  logic [MAX_LEN*IDX_W-1:0] index_data;
  logic [IDX_W-1:0]         food_pos;
  logic                     food_valid;
`ifdef SCORE_OVERLAY_EN
  logic [IDX_W-1:0]         score_position;
`endif
  logic [IDX_W:0]           cnt_pixel;
  logic [4:0]               cnt_bit;
  logic                     busy;
  logic                     frame_done;
  logic                     ser_bit;

  modport master (
`ifdef SCORE_OVERLAY_EN
    output score_position,
`endif
    output frame_req, snake_len, index_data, food_pos, food_valid,
    output cnt_pixel, cnt_bit,
    input  busy, frame_done, ser_bit
  );

  modport slave (
`ifdef SCORE_OVERLAY_EN
    input  score_position,
`endif
    input  frame_req, snake_len, index_data, food_pos, food_valid,
    input  cnt_pixel, cnt_bit,
    output busy, frame_done, ser_bit
  );
endinterface

// File: rtl/snake_pix_buf.sv
// Double-buffered pixel store: writes go to the back bank, reads
// come combinationally from the front bank selected by sel.
module snake_pix_buf #(
  parameter int N_PIX   = 64,
  parameter int AW      = 6,
  parameter int COLOR_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sel,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [COLOR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [COLOR_W-1:0] rdata
);

  logic [COLOR_W-1:0] bank_q [2][N_PIX];
  logic [COLOR_W-1:0] bank_d [2][N_PIX];

  // Next-state of both banks: single write into the back bank
  always_comb begin
    bank_d = bank_q;
    if (we) bank_d[~sel][waddr] = wdata;
  end

  // Bank storage, cleared on reset so the serial output reads dark
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned p = 0; p < N_PIX; p++)
          bank_q[b][p] <= '0;
    end else begin
      bank_q <= bank_d;
    end
  end

  // Front-bank read port
  always_comb rdata = bank_q[sel][raddr];

endmodule

// File: rtl/snake_frame_builder.sv
// Composes one snake frame into the back buffer on request and serves
// the front buffer bit-by-bit to the LED serialiser.
// SCORE_OVERLAY_EN adds a one-cycle SCORE pixel write after CLEAR.
module snake_frame_builder
  import snake_pkg::*;
#(
  parameter int GRID_W  = 8,
  parameter int GRID_H  = 8,
  parameter int MAX_LEN = 8,
  parameter int IDX_W   = 6,
  parameter int COLOR_W = 24
) (
  input logic                 sys_clk,
  input logic                 sys_rst_n,
  snake_frame_builder_if.slave sif
);

  localparam int N_PIX = GRID_W * GRID_H;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int BIT_W = $clog2(COLOR_W);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         clr_q, clr_d;
  logic [LEN_W-1:0]         seg_q, seg_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [MAX_LEN*IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0]         food_q, food_d;
  logic                     fv_q, fv_d;
  logic                     sel_q, sel_d;
  logic                     done_q, done_d;
`ifdef SCORE_OVERLAY_EN
  logic [IDX_W-1:0]         score_q, score_d;
`endif

  logic                     wr_en;
  logic [IDX_W-1:0]         wr_addr;
  logic [COLOR_W-1:0]       wr_data;
  logic [IDX_W-1:0]         seg_idx;
  logic [IDX_W-1:0]         rd_addr;
  logic [COLOR_W-1:0]       rd_word;
  logic                     rd_ok;
  logic [BIT_W-1:0]         bit_sel;

  // Pixel index of the segment currently being drawn (head in top bits)
  always_comb seg_idx = idx_q[(MAX_LEN - 1 - int'(seg_q)) * IDX_W +: IDX_W];

  // Next-state, snapshot and back-buffer write generation
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    seg_d   = seg_q;
    len_d   = len_q;
    idx_d   = idx_q;
    food_d  = food_q;
    fv_d    = fv_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
`ifdef SCORE_OVERLAY_EN
    score_d = score_q;
`endif
    wr_en   = 1'b0;
    wr_addr = clr_q;
    wr_data = COLOR_W'(BG_COLOR);
    case (state_q)
      IDLE: begin
        if (sif.frame_req) begin
          len_d  = (int'(sif.snake_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : sif.snake_len;
          idx_d  = sif.index_data;
          food_d = sif.food_pos;
          fv_d   = sif.food_valid;
`ifdef SCORE_OVERLAY_EN
          score_d = sif.score_position;
`endif
          clr_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        wr_en = 1'b1;
        clr_d = clr_q + 1'b1;
        if (int'(clr_q) == N_PIX - 1) begin
`ifdef SCORE_OVERLAY_EN
          state_d = SCORE;
`else
          state_d = FOOD;
`endif
        end
      end
`ifdef SCORE_OVERLAY_EN
      SCORE: begin
        wr_en   = int'(score_q) < N_PIX;
        wr_addr = score_q;
        wr_data = COLOR_W'(SCORE_COLOR);
        state_d = FOOD;
      end
`endif
      FOOD: begin
        wr_en   = fv_q && (int'(food_q) < N_PIX);
        wr_addr = food_q;
        wr_data = COLOR_W'(FOOD_COLOR);
        if (len_q == '0) begin
          state_d = SWAP;
        end else begin
          seg_d   = len_q - 1'b1;
          state_d = BODY;
        end
      end
      BODY: begin
        wr_en   = int'(seg_idx) < N_PIX;
        wr_addr = seg_idx;
        wr_data = (seg_q == '0) ? COLOR_W'(HEAD_COLOR) : COLOR_W'(BODY_COLOR);
        if (seg_q == '0) state_d = SWAP;
        else             seg_d   = seg_q - 1'b1;
      end
      SWAP: begin
        // frame_done is registered so its pulse lines up with the new front bank
        sel_d   = ~sel_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, counters and frame snapshot registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      clr_q   <= '0;
      seg_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      food_q  <= '0;
      fv_q    <= 1'b0;
      sel_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef SCORE_OVERLAY_EN
      score_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      seg_q   <= seg_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      food_q  <= food_d;
      fv_q    <= fv_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
`ifdef SCORE_OVERLAY_EN
      score_q <= score_d;
`endif
    end
  end

  snake_pix_buf #(
    .N_PIX   (N_PIX),
    .AW      (IDX_W),
    .COLOR_W (COLOR_W)
  ) u_pix_buf (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .sel   (sel_q),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  // Serial read: MSB first, dark outside the grid or past the last bit
  always_comb begin
    rd_addr = sif.cnt_pixel[IDX_W-1:0];
    rd_ok   = (int'(sif.cnt_pixel) < N_PIX) && (int'(sif.cnt_bit) < COLOR_W);
    bit_sel = '0;
    if (rd_ok) bit_sel = BIT_W'(COLOR_W - 1 - int'(sif.cnt_bit));
    sif.ser_bit = rd_ok & rd_word[bit_sel];
  end

  assign sif.busy       = (state_q != IDLE);
  assign sif.frame_done = done_q;

endmodule

// File: tb/tb_snake_frame_builder.sv
// Directed self-checking bench for snake_frame_builder.
module tb_snake_frame_builder;

`ifdef SCORE_OVERLAY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic sys_clk;
  logic sys_rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   pulses   = 0;

  snake_frame_builder_if #(.MAX_LEN(8), .IDX_W(6)) sif ();

  snake_frame_builder #(
    .GRID_W  (8),
    .GRID_H  (8),
    .MAX_LEN (8),
    .IDX_W   (6),
    .COLOR_W (24)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .sif       (sif)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) if (sif.frame_done === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic read_pix(input int p, output logic [23:0] w);
    for (int b = 0; b < 24; b++) begin
      sif.cnt_pixel = 7'(p);
      sif.cnt_bit   = 5'(b);
      #1;
      w[23-b] = sif.ser_bit;
    end
  endtask

  task automatic count_lit(output int n);
    logic [23:0] w;
    n = 0;
    for (int p = 0; p < 64; p++) begin
      read_pix(p, w);
      if (w !== 24'h0) n++;
    end
  endtask

  task automatic run_frame(input int len, input logic [47:0] idx, input logic [5:0] food,
                           input logic fv, input int dup_at, input int abort_at,
                           input int ppix, input int pbit,
                           output int lat, output logic pmid, output logic pdone);
    @(negedge sys_clk);
    sif.snake_len  = 4'(len);
    sif.index_data = idx;
    sif.food_pos   = food;
    sif.food_valid = fv;
    sif.cnt_pixel  = 7'(ppix);
    sif.cnt_bit    = 5'(pbit);
    sif.frame_req  = 1'b1;
    @(posedge sys_clk);
    lat = 1;
    @(negedge sys_clk);
    sif.frame_req = 1'b0;
    check("busy_start", {31'd0, sif.busy}, 32'd1);
    pmid  = 1'bx;
    pdone = 1'bx;
    while (sif.frame_done !== 1'b1 && lat < 200) begin
      sif.frame_req = (lat == dup_at);
      if (lat == 30) begin
        #1;
        pmid = sif.ser_bit;
      end
      if (lat == abort_at) begin
        sys_rst_n = 1'b0;
        #1;
        break;
      end
      @(posedge sys_clk);
      lat++;
      @(negedge sys_clk);
    end
    sif.frame_req = 1'b0;
    if (sif.frame_done === 1'b1) begin
      #1;
      pdone = sif.ser_bit;
      check("busy_end", {31'd0, sif.busy}, 32'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int          lat, n, p0;
    logic        pm, pd;
    logic [23:0] w;

    sys_rst_n      = 1'b0;
    sif.frame_req  = 1'b0;
    sif.snake_len  = '0;
    sif.index_data = '0;
    sif.food_pos   = '0;
    sif.food_valid = 1'b0;
    sif.cnt_pixel  = '0;
    sif.cnt_bit    = '0;
`ifdef SCORE_OVERLAY_EN
    sif.score_position = 6'd33;
`endif
    repeat (3) @(negedge sys_clk);
    check("rst_busy", {31'd0, sif.busy}, 32'd0);
    check("rst_done", {31'd0, sif.frame_done}, 32'd0);
    sys_rst_n = 1'b1;
    count_lit(n);
    check("idle_dark", n, 0);
    repeat (20) @(negedge sys_clk);
    check("idle_no_pulse", pulses, 0);
    check("idle_busy", {31'd0, sif.busy}, 32'd0);

    // Frame A: head 10, body 11..13, food 40
    run_frame(4, {6'd10, 6'd11, 6'd12, 6'd13, 24'd0}, 6'd40, 1'b1, -1, -1, 10, 3, lat, pm, pd);
    check("a_latency", lat, 71 + EXTRA);
    check("a_probe_mid", {31'd0, pm}, 32'd0);
    check("a_probe_done", {31'd0, pd}, 32'd1);
    read_pix(10, w); check("a_pix10", {8'd0, w}, 32'h111100);
    read_pix(11, w); check("a_pix11", {8'd0, w}, 32'h110000);
    read_pix(12, w); check("a_pix12", {8'd0, w}, 32'h110000);
    read_pix(13, w); check("a_pix13", {8'd0, w}, 32'h110000);
    read_pix(40, w); check("a_pix40", {8'd0, w}, 32'h001100);
    read_pix(0, w);  check("a_pix0", {8'd0, w}, 32'h0);
    count_lit(n);    check("a_lit", n, 5 + EXTRA);
    sif.cnt_pixel = 7'd10; sif.cnt_bit = 5'd24; #1;
    check("a_bit_oor", {31'd0, sif.ser_bit}, 32'd0);
    sif.cnt_pixel = 7'd64; sif.cnt_bit = 5'd3; #1;
    check("a_pix_oor", {31'd0, sif.ser_bit}, 32'd0);

    // Frame B: head, body and food all on pixel 20; extra request dropped
    p0 = pulses;
    run_frame(2, {6'd20, 6'd20, 36'd0}, 6'd20, 1'b1, 5, -1, 10, 3, lat, pm, pd);
    check("b_latency", lat, 69 + EXTRA);
    check("b_no_tear_mid", {31'd0, pm}, 32'd1);
    check("b_swap_at_done", {31'd0, pd}, 32'd0);
    repeat (80) @(negedge sys_clk);
    check("b_one_pulse", pulses - p0, 1);
    check("b_idle_busy", {31'd0, sif.busy}, 32'd0);
    read_pix(20, w); check("b_pix20", {8'd0, w}, 32'h111100);
    count_lit(n);    check("b_lit", n, 1 + EXTRA);

    // Frame C: len 0, only food
    run_frame(0, {6'd7, 42'd0}, 6'd5, 1'b1, -1, -1, 0, 0, lat, pm, pd);
    check("c_latency", lat, 67 + EXTRA);
    read_pix(5, w); check("c_pix5", {8'd0, w}, 32'h001100);
    read_pix(7, w); check("c_pix7", {8'd0, w}, 32'h0);
    count_lit(n);   check("c_lit", n, 1 + EXTRA);

    // Frame D: len 15 clamps to 8, head on pixel 63, no food
    run_frame(15, {6'd63, 6'd62, 6'd61, 6'd60, 6'd59, 6'd58, 6'd57, 6'd56}, 6'd0, 1'b0,
              -1, -1, 0, 0, lat, pm, pd);
    check("d_latency", lat, 75 + EXTRA);
    read_pix(63, w); check("d_pix63", {8'd0, w}, 32'h111100);
    read_pix(56, w); check("d_pix56", {8'd0, w}, 32'h110000);
    read_pix(0, w);  check("d_pix0", {8'd0, w}, 32'h0);
    count_lit(n);    check("d_lit", n, 8 + EXTRA);

    // Frame E: reset during BODY, then a clean frame
    run_frame(8, {6'd63, 6'd62, 6'd61, 6'd60, 6'd59, 6'd58, 6'd57, 6'd56}, 6'd0, 1'b0,
              -1, 68 + EXTRA, 63, 3, lat, pm, pd);
    check("e_abort_reached", lat, 68 + EXTRA);
    check("e_front_before", {31'd0, pm}, 32'd1);
    check("e_bit_after_rst", {31'd0, sif.ser_bit}, 32'd0);
    check("e_busy_after_rst", {31'd0, sif.busy}, 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    run_frame(4, {6'd10, 6'd11, 6'd12, 6'd13, 24'd0}, 6'd40, 1'b1, -1, -1, 0, 0, lat, pm, pd);
    check("e_latency", lat, 71 + EXTRA);
    read_pix(10, w); check("e_pix10", {8'd0, w}, 32'h111100);
    read_pix(63, w); check("e_pix63", {8'd0, w}, 32'h0);
    count_lit(n);    check("e_lit", n, 5 + EXTRA);

`ifdef SCORE_OVERLAY_EN
    sif.score_position = 6'd63;
    run_frame(4, {6'd10, 6'd11, 6'd12, 6'd13, 24'd0}, 6'd40, 1'b1, -1, -1, 0, 0, lat, pm, pd);
    check("s_latency", lat, 72);
    read_pix(63, w); check("s_pix63", {8'd0, w}, 32'h000011);
    count_lit(n);    check("s_lit", n, 6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
